fft_bin_serializer: RTL and testbench
=====================================

// Module: fft_bin_serializer
// PURPOSE
//  Downstream of the 16-point OFDM FFT. Snapshots all BINS parallel complex FFT outputs
//  when the FFT's cycle-done strobe pulses, then streams them bin 0..BINS-1, one per beat,
//  over a valid/ready interface to the demodulation/readout stage. Flags frames that are
//  lost because the previous frame is still streaming.
// PARAMETERS
//  N      16  word width of each re/im sample (two's complement)
//  Q      8   fractional bits (pass-through only; no arithmetic rescale)
//  BINS   16  bins per frame; IDX_W = $clog2(BINS) = 4
// PORTS
//  i_clk       in   1        system clock, rising edge
//  i_rst       in   1        asynchronous, active-high reset
//  i_fft_done  in   1        1-cycle strobe: i_bins_re/im hold a complete frame this cycle
//  i_bins_re   in   BINS*N   bin k real part at [k*N +: N]
//  i_bins_im   in   BINS*N   bin k imaginary part at [k*N +: N]
//  o_valid     out  1        output beat valid
//  i_ready     in   1        consumer accepts beat when o_valid & i_ready
//  o_re        out  N        current bin real part
//  o_im        out  N        current bin imaginary part
//  o_idx       out  IDX_W    current bin index
//  o_last      out  1        high with bin BINS-1
//  o_busy      out  1        frame buffer occupied (state STREAM)
//  o_overrun   out  1        sticky: a frame was dropped
//  o_sym       out  2        QPSK hard decision of current bin (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE; o_valid, o_re, o_im, o_idx, o_last, o_busy,
//    o_overrun, o_sym all 0; frame buffer contents don't-care.
//  - FSM IDLE: on i_fft_done latch all BINS re/im words into the frame buffer, idx<=0,
//    go STREAM. o_valid rises the cycle after the strobe (latency 1 clock).
//  - FSM STREAM: o_valid=1, o_busy=1; o_re/o_im = buffer[idx], o_idx=idx, o_last=(idx==BINS-1).
//    On transfer (o_valid & i_ready) with idx<BINS-1: idx<=idx+1.
//    On transfer with idx==BINS-1: if i_fft_done same cycle, latch new frame, idx<=0, stay
//    STREAM (back-to-back, no bubble); else go IDLE, o_valid<=0, o_busy<=0.
//  - i_fft_done in STREAM other than on the final transfer: new frame dropped, buffer and
//    idx untouched, o_overrun<=1 (held until reset).
//  - While o_valid & !i_ready: o_re, o_im, o_idx, o_last, o_sym stable; no limit on stall.
//  - All outputs registered; no combinational path from i_ready to o_valid.
//  - Minimum frame period for lossless operation: BINS cycles with i_ready held high.
//  - Reset mid-frame: stream aborted, partial frame discarded; no o_last is produced.
// CONFIGURATION
//  FFT_SER_QPSK_DEMAP_EN defined: o_sym = {o_im[N-1], o_re[N-1]} (1 = negative), registered
//   and aligned with o_re/o_im; zero is treated as positive.
//  Not defined: o_sym tied to 2'b00; no demap logic.
// TESTING
//  1 Reset: assert i_rst mid-stream -> all outputs 0 immediately; o_overrun cleared.
//  2 Single frame, i_ready=1: bin k re=k*16'h0010, im=-k; strobe at cycle T -> o_valid
//    T+1..T+16, o_idx 0..15, o_re 0x0000..0x00F0, o_im 0x0000..0xFFF1, o_last only at idx 15.
//  3 Backpressure: i_ready low for 3 cycles at idx 5 -> o_idx=5, data stable, then resumes
//    at 6; 16 beats total, none duplicated or skipped.
//  4 Back-to-back: second strobe on the idx-15 transfer cycle -> next beat is idx 0 of frame 2,
//    no idle cycle; o_overrun stays 0.
//  5 Overrun: second strobe at idx 7 -> frame 1 completes unchanged, o_overrun=1 thereafter,
//    block returns to IDLE after idx 15.
//  6 Demap (macro on): bins (0x016A,0x00C9),(0xFE96,0x00C9),(0x016A,0xFF37),(0xFE96,0xFF37)
//    -> o_sym 2'b00, 2'b01, 2'b10, 2'b11; macro off -> o_sym 2'b00 always.

Source files
------------

// File: rtl/fft_bin_serializer_if.sv
// Handshake and bus bundle between the FFT, the bin serializer and the demod/readout stage.
// master = serializer side, slave = FFT/consumer side.
interface fft_bin_serializer_if #(
    parameter int N    = 16,
    parameter int BINS = 16
);
    localparam int IDX_W = $clog2(BINS);

    logic                fft_done;
    logic [BINS*N-1:0]   bins_re;
    logic [BINS*N-1:0]   bins_im;
    logic                valid;
    logic                ready;
    logic [N-1:0]        re;
    logic [N-1:0]        im;
    logic [IDX_W-1:0]    idx;
    logic                last;
    logic                busy;
    logic                overrun;
    logic [1:0]          sym;

    modport master (
        input  fft_done, bins_re, bins_im, ready,
        output valid, re, im, idx, last, busy, overrun, sym
    );

    modport slave (
        output fft_done, bins_re, bins_im, ready,
        input  valid, re, im, idx, last, busy, overrun, sym
    );
endinterface

// File: rtl/fft_bin_serializer.sv
// Snapshots a parallel FFT frame on fft_done and streams its bins 0..BINS-1 over valid/ready.
// Optional QPSK hard-decision output enabled by defining FFT_SER_QPSK_DEMAP_EN.
module fft_bin_serializer #(
    parameter int N    = 16,
    parameter int Q    = 8,
    parameter int BINS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    fft_bin_serializer_if.master   bus
);
    localparam int IDX_W = $clog2(BINS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BINS - 1);

    // Q only documents the fixed-point format of the pass-through samples.
    if (Q < 0 || Q >= N) begin : g_q_check
        $error("fft_bin_serializer: Q must lie in 0..N-1");
    end

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t              state;
    logic                valid_q;
    logic                last_q;
    logic                busy_q;
    logic                overrun_q;
    logic [N-1:0]        re_q;
    logic [N-1:0]        im_q;
    logic [IDX_W-1:0]    idx_q;
    logic [BINS*N-1:0]   frame_re;
    logic [BINS*N-1:0]   frame_im;

    logic                at_last;
    logic                xfer;
    logic                load;
    logic                advance;
    logic                drop;
    logic [IDX_W-1:0]    next_idx;
    logic [N-1:0]        next_re;
    logic [N-1:0]        next_im;

    // A new frame is accepted when idle, or exactly on the final transfer of the current one.
    always_comb begin
        at_last  = (idx_q == LAST_IDX);
        xfer     = valid_q & bus.ready;
        load     = bus.fft_done & ((state == IDLE) | ((state == STREAM) & xfer & at_last));
        advance  = (state == STREAM) & xfer & ~at_last;
        drop     = bus.fft_done & (state == STREAM) & ~(xfer & at_last);
        next_idx = load ? '0 : idx_q + 1'b1;
        next_re  = load ? bus.bins_re[N-1:0] : frame_re[next_idx*N +: N];
        next_im  = load ? bus.bins_im[N-1:0] : frame_im[next_idx*N +: N];
    end

    // Frame buffer has no reset; its contents only matter after a load.
    always_ff @(posedge clk) begin
        if (load) begin
            frame_re <= bus.bins_re;
            frame_im <= bus.bins_im;
        end
    end

`ifdef FFT_SER_QPSK_DEMAP_EN
    logic [1:0] sym_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            re_q      <= '0;
            im_q      <= '0;
            idx_q     <= '0;
`ifdef FFT_SER_QPSK_DEMAP_EN
            sym_q     <= 2'b00;
`endif
        end else begin
            if (load || advance) begin
                idx_q  <= next_idx;
                re_q   <= next_re;
                im_q   <= next_im;
                last_q <= (next_idx == LAST_IDX);
`ifdef FFT_SER_QPSK_DEMAP_EN
                sym_q  <= {next_im[N-1], next_re[N-1]};
`endif
            end

            if (drop) begin
                overrun_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (load) begin
                        state   <= STREAM;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (xfer && at_last && !bus.fft_done) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        last_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.valid   = valid_q;
    assign bus.re      = re_q;
    assign bus.im      = im_q;
    assign bus.idx     = idx_q;
    assign bus.last    = last_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;
`ifdef FFT_SER_QPSK_DEMAP_EN
    assign bus.sym     = sym_q;
`else
    assign bus.sym     = 2'b00;
`endif

endmodule

// File: tb/tb_fft_bin_serializer.sv
// Directed self-checking bench for fft_bin_serializer: reset, streaming, backpressure,
// back-to-back frames, overrun and QPSK demap (FFT_SER_QPSK_DEMAP_EN aware).
module tb_fft_bin_serializer;
    localparam int N    = 16;
    localparam int Q    = 8;
    localparam int BINS = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [N-1:0] tb_re [3][BINS];
    logic [N-1:0] tb_im [3][BINS];

    fft_bin_serializer_if #(.N(N), .BINS(BINS)) bus ();

    fft_bin_serializer #(.N(N), .Q(Q), .BINS(BINS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_sym(input int f, input int k);
`ifdef FFT_SER_QPSK_DEMAP_EN
        logic [N-1:0] r;
        logic [N-1:0] i;
        r = tb_re[f][k];
        i = tb_im[f][k];
        return {i[N-1], r[N-1]};
`else
        return 2'b00;
`endif
    endfunction

    task automatic apply_stimulus(input int f);
        for (int k = 0; k < BINS; k++) begin
            bus.bins_re[k*N +: N] = tb_re[f][k];
            bus.bins_im[k*N +: N] = tb_im[f][k];
        end
    endtask

    task automatic check_beat(input string tag, input int f, input int k);
        check_output({tag, "_valid"}, 32'(bus.valid), 32'd1);
        check_output({tag, "_busy"},  32'(bus.busy),  32'd1);
        check_output({tag, "_idx"},   32'(bus.idx),   32'(k));
        check_output({tag, "_re"},    32'(bus.re),    32'(tb_re[f][k]));
        check_output({tag, "_im"},    32'(bus.im),    32'(tb_im[f][k]));
        check_output({tag, "_last"},  32'(bus.last),  32'(k == BINS - 1));
        check_output({tag, "_sym"},   32'(bus.sym),   32'(exp_sym(f, k)));
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_valid"}, 32'(bus.valid), 32'd0);
        check_output({tag, "_busy"},  32'(bus.busy),  32'd0);
        check_output({tag, "_last"},  32'(bus.last),  32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Frame 0: re = k*0x10, im = -k. Frame 1: re = 0x8000+k, im = k*0x100.
        // Frame 2: four QPSK points then zeros.
        for (int k = 0; k < BINS; k++) begin
            tb_re[0][k] = 16'(k * 16);
            tb_im[0][k] = 16'(-k);
            tb_re[1][k] = 16'(16'h8000 + k);
            tb_im[1][k] = 16'(k * 256);
            tb_re[2][k] = 16'h0000;
            tb_im[2][k] = 16'h0000;
        end
        tb_re[2][0] = 16'h016A; tb_im[2][0] = 16'h00C9;
        tb_re[2][1] = 16'hFE96; tb_im[2][1] = 16'h00C9;
        tb_re[2][2] = 16'h016A; tb_im[2][2] = 16'hFF37;
        tb_re[2][3] = 16'hFE96; tb_im[2][3] = 16'hFF37;

        rst          = 1'b1;
        bus.ready    = 1'b1;
        bus.fft_done = 1'b0;
        bus.bins_re  = '0;
        bus.bins_im  = '0;

        $display("[TB] reset state");
        repeat (2) @(negedge clk);
        check_idle("rst0");
        check_output("rst0_re",      32'(bus.re),      32'd0);
        check_output("rst0_im",      32'(bus.im),      32'd0);
        check_output("rst0_idx",     32'(bus.idx),     32'd0);
        check_output("rst0_overrun", 32'(bus.overrun), 32'd0);
        check_output("rst0_sym",     32'(bus.sym),     32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst0_rel");

        $display("[TB] single frame, ready high");
        apply_stimulus(0);
        bus.fft_done = 1'b1;
        @(negedge clk);
        bus.fft_done = 1'b0;
        for (int k = 0; k < BINS; k++) begin
            check_beat("single", 0, k);
            @(negedge clk);
        end
        check_idle("single_end");
        check_output("single_overrun", 32'(bus.overrun), 32'd0);

        $display("[TB] backpressure at idx 5");
        apply_stimulus(0);
        bus.fft_done = 1'b1;
        @(negedge clk);
        bus.fft_done = 1'b0;
        for (int k = 0; k < BINS; k++) begin
            check_beat("bp", 0, k);
            if (k == 5) begin
                bus.ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_beat("bp_stall", 0, 5);
                end
                bus.ready = 1'b1;
            end
            @(negedge clk);
        end
        check_idle("bp_end");

        $display("[TB] back-to-back frames");
        apply_stimulus(0);
        bus.fft_done = 1'b1;
        @(negedge clk);
        bus.fft_done = 1'b0;
        for (int k = 0; k < BINS; k++) begin
            check_beat("b2b_f0", 0, k);
            if (k == BINS - 1) begin
                apply_stimulus(1);
                bus.fft_done = 1'b1;
            end
            @(negedge clk);
            bus.fft_done = 1'b0;
        end
        for (int k = 0; k < BINS; k++) begin
            check_beat("b2b_f1", 1, k);
            check_output("b2b_overrun", 32'(bus.overrun), 32'd0);
            @(negedge clk);
        end
        check_idle("b2b_end");

        $display("[TB] overrun at idx 7");
        apply_stimulus(0);
        bus.fft_done = 1'b1;
        @(negedge clk);
        bus.fft_done = 1'b0;
        for (int k = 0; k < BINS; k++) begin
            check_beat("ovr", 0, k);
            check_output("ovr_flag", 32'(bus.overrun), 32'(k > 7));
            if (k == 7) begin
                apply_stimulus(1);
                bus.fft_done = 1'b1;
            end
            @(negedge clk);
            bus.fft_done = 1'b0;
        end
        check_idle("ovr_end");
        check_output("ovr_sticky", 32'(bus.overrun), 32'd1);
        @(negedge clk);
        check_idle("ovr_end2");

        $display("[TB] QPSK demap points");
        apply_stimulus(2);
        bus.fft_done = 1'b1;
        @(negedge clk);
        bus.fft_done = 1'b0;
        for (int k = 0; k < BINS; k++) begin
            check_beat("demap", 2, k);
            if (k < 4) begin
`ifdef FFT_SER_QPSK_DEMAP_EN
                check_output("demap_tbl", 32'(bus.sym), 32'(k));
`else
                check_output("demap_tbl", 32'(bus.sym), 32'd0);
`endif
            end
            @(negedge clk);
        end
        check_idle("demap_end");

        $display("[TB] reset mid-stream");
        apply_stimulus(0);
        bus.fft_done = 1'b1;
        @(negedge clk);
        bus.fft_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_beat("mid", 0, k);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check_idle("mid_rst");
        check_output("mid_rst_re",      32'(bus.re),      32'd0);
        check_output("mid_rst_im",      32'(bus.im),      32'd0);
        check_output("mid_rst_idx",     32'(bus.idx),     32'd0);
        check_output("mid_rst_overrun", 32'(bus.overrun), 32'd0);
        check_output("mid_rst_sym",     32'(bus.sym),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_idle("mid_after");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
